time_set_controller: RTL and testbench

TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

---
 rtl/time_set_controller.sv | 175 +++++++++++++++++
 tb/tb_time_set_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/time_set_controller.sv
// Time-set front end: synchronizes and debounces the minute/hour buttons, generates
// auto-repeat set pulses and a minute tick, and arbitrates them onto three exclusive pulses.
module time_set_controller #(
   parameter int TICK_DIV        = 60,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 16,
   parameter int REPEAT_PERIOD   = 4
) (
   input  logic Clock,
   input  logic nReset,
   input  logic MinButton,
   input  logic HourButton,
   output logic Tick,
   output logic SyncMinOut,
   output logic SyncHourOut,
   output logic Setting
);

   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RTW = $clog2(((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
   localparam int PSW = $clog2(TICK_DIV);

   typedef enum logic [2:0] {
      ST_IDLE          = 3'd0,
      ST_DEB_PRESS     = 3'd1,
      ST_HELD_DELAY    = 3'd2,
      ST_REPEAT        = 3'd3,
      ST_DEB_RELEASE   = 3'd4
   } state_t;

   // Index 0 is the minute button, index 1 the hour button.
   logic [1:0]     r_sync1;
   logic [1:0]     r_sync2;
   state_t         r_state   [2];
   logic [1:0]     r_ret_rep;
   logic [DBW-1:0] r_dcnt    [2];
   logic [RTW-1:0] r_rtimer  [2];
   logic [PSW-1:0] r_presc;
   logic           r_pend_hour;
   logic           r_pend_tick;

   logic [1:0]     w_req;
   logic           w_wrap;
   logic           w_min;
   logic           w_hour_any;
   logic           w_tick_any;

   // Two-flop synchronizers for the raw buttons.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_sync1 <= 2'b00;
         r_sync2 <= 2'b00;
      end else begin
         r_sync1 <= {HourButton, MinButton};
         r_sync2 <= r_sync1;
      end
   end

   // Pulse requests are raised on the edge at which each FSM reaches its count.
   always_comb begin
      w_req = 2'b00;
      for (int b = 0; b < 2; b++) begin
         case (r_state[b])
            ST_DEB_PRESS:  w_req[b] = r_sync2[b] && (r_dcnt[b] == DBW'(DEBOUNCE_CYCLES - 1));
            ST_HELD_DELAY: w_req[b] = r_sync2[b] && (r_rtimer[b] == RTW'(REPEAT_DELAY - 1));
            ST_REPEAT:     w_req[b] = r_sync2[b] && (r_rtimer[b] == RTW'(REPEAT_PERIOD - 1));
            default:       w_req[b] = 1'b0;
         endcase
      end
   end

   // Per-button debounce / auto-repeat FSMs.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_ret_rep <= 2'b00;
         for (int b = 0; b < 2; b++) begin
            r_state[b]  <= ST_IDLE;
            r_dcnt[b]   <= '0;
            r_rtimer[b] <= '0;
         end
      end else begin
         for (int b = 0; b < 2; b++) begin
            case (r_state[b])
               ST_IDLE: begin
                  if (r_sync2[b]) begin
                     r_state[b] <= ST_DEB_PRESS;
                     r_dcnt[b]  <= '0;
                  end
               end
               ST_DEB_PRESS: begin
                  if (!r_sync2[b]) begin
                     r_state[b] <= ST_IDLE;
                  end else if (r_dcnt[b] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                     r_state[b]  <= ST_HELD_DELAY;
                     r_rtimer[b] <= '0;
                  end else begin
                     r_dcnt[b] <= r_dcnt[b] + DBW'(1);
                  end
               end
               ST_HELD_DELAY: begin
                  // The first low sample already counts toward the release debounce.
                  if (!r_sync2[b]) begin
                     r_state[b]   <= ST_DEB_RELEASE;
                     r_ret_rep[b] <= 1'b0;
                     r_dcnt[b]    <= DBW'(1);
                  end else if (r_rtimer[b] == RTW'(REPEAT_DELAY - 1)) begin
                     r_state[b]  <= ST_REPEAT;
                     r_rtimer[b] <= '0;
                  end else begin
                     r_rtimer[b] <= r_rtimer[b] + RTW'(1);
                  end
               end
               ST_REPEAT: begin
                  if (!r_sync2[b]) begin
                     r_state[b]   <= ST_DEB_RELEASE;
                     r_ret_rep[b] <= 1'b1;
                     r_dcnt[b]    <= DBW'(1);
                  end else if (r_rtimer[b] == RTW'(REPEAT_PERIOD - 1)) begin
                     r_rtimer[b] <= '0;
                  end else begin
                     r_rtimer[b] <= r_rtimer[b] + RTW'(1);
                  end
               end
               ST_DEB_RELEASE: begin
                  // Repeat timer stays frozen here so a bounce resumes the old cadence.
                  if (r_sync2[b]) begin
                     r_state[b] <= r_ret_rep[b] ? ST_REPEAT : ST_HELD_DELAY;
                  end else if (r_dcnt[b] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                     r_state[b] <= ST_IDLE;
                  end else begin
                     r_dcnt[b] <= r_dcnt[b] + DBW'(1);
                  end
               end
               default: begin
                  r_state[b] <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign w_wrap     = (r_presc == PSW'(TICK_DIV - 1));
   assign w_min      = w_req[0];
   assign w_hour_any = w_req[1] | r_pend_hour;
   assign w_tick_any = w_wrap | r_pend_tick;

   // Prescaler and priority arbiter; a minute pulse restarts the minute and drops any tick.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_presc     <= '0;
         r_pend_hour <= 1'b0;
         r_pend_tick <= 1'b0;
         SyncMinOut  <= 1'b0;
         SyncHourOut <= 1'b0;
         Tick        <= 1'b0;
      end else begin
         if (w_min || w_wrap) begin
            r_presc <= '0;
         end else begin
            r_presc <= r_presc + PSW'(1);
         end
         SyncMinOut  <= w_min;
         SyncHourOut <= !w_min && w_hour_any;
         Tick        <= !w_min && !w_hour_any && w_tick_any;
         r_pend_hour <= w_min && w_hour_any;
         r_pend_tick <= !w_min && w_hour_any && w_tick_any;
      end
   end

   // Setting follows the FSM states directly.
   always_comb begin
      Setting = (r_state[0] != ST_IDLE) || (r_state[1] != ST_IDLE);
   end

endmodule

// File: tb/tb_time_set_controller.sv
// Scoreboard bench for time_set_controller: expected pulses (edge number, kind) are queued
// when stimulus is applied and matched against every observed output pulse.
module tb_time_set_controller;

   localparam int K_MIN  = 1;
   localparam int K_HOUR = 2;
   localparam int K_TICK = 3;

   logic Clock = 1'b0;
   logic nReset = 1'b0;
   logic MinButton = 1'b0;
   logic HourButton = 1'b0;
   logic Tick, SyncMinOut, SyncHourOut, Setting;

   typedef struct {
      int cyc;
      int kind;
   } exp_t;

   exp_t sb_q[$];
   int   edge_n = 0;
   int   n_vec = 0;
   int   n_err = 0;

   time_set_controller dut (
      .Clock      (Clock),
      .nReset     (nReset),
      .MinButton  (MinButton),
      .HourButton (HourButton),
      .Tick       (Tick),
      .SyncMinOut (SyncMinOut),
      .SyncHourOut(SyncHourOut),
      .Setting    (Setting)
   );

   always #5 Clock = ~Clock;

   // Edge number since the last reset release (first edge after release is 1).
   always @(posedge Clock) begin
      if (!nReset) edge_n <= 0;
      else         edge_n <= edge_n + 1;
   end

   task automatic check_val(input string tag, input int obs, input int exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (edge %0d)", tag, obs, exp_v, edge_n);
      end
   endtask

   task automatic push_exp(input int c, input int k);
      exp_t e;
      e.cyc  = c;
      e.kind = k;
      sb_q.push_back(e);
   endtask

   task automatic wait_edge(input int n);
      int guard;
      guard = 0;
      while (edge_n < n && guard < 5000) begin
         @(negedge Clock);
         guard++;
      end
      if (edge_n < n) check_val("timeout", edge_n, n);
   endtask

   task automatic do_reset(input logic min_held);
      @(negedge Clock);
      nReset = 1'b0;
      MinButton = min_held;
      HourButton = 1'b0;
      #1;
      check_val("rst_outs", int'({Tick, SyncMinOut, SyncHourOut, Setting}), 0);
      @(negedge Clock);
      @(negedge Clock);
      nReset = 1'b1;
   endtask

   // Scoreboard monitor, sampling on the falling edge.
   always @(negedge Clock) begin
      exp_t e;
      int   code;
      if (nReset === 1'b1 && (Tick || SyncMinOut || SyncHourOut)) begin
         code = SyncMinOut ? K_MIN : (SyncHourOut ? K_HOUR : K_TICK);
         check_val("excl", $countones({Tick, SyncMinOut, SyncHourOut}), 1);
         if (sb_q.size() == 0) begin
            check_val("unexpected", code, 0);
         end else begin
            e = sb_q.pop_front();
            check_val("kind", code, e.kind);
            check_val("cycle", edge_n, e.cyc);
         end
      end
   end

   initial begin
      // Idle buttons: ticks only, every TICK_DIV edges.
      do_reset(1'b0);
      push_exp(60, K_TICK);
      push_exp(120, K_TICK);
      push_exp(180, K_TICK);
      wait_edge(200);
      check_val("idle_setting", int'(Setting), 0);
      check_val("idle_left", sb_q.size(), 0);

      // Short bounce: too few stable samples, no set pulse.
      do_reset(1'b0);
      push_exp(60, K_TICK);
      wait_edge(10);
      MinButton = 1'b1;
      wait_edge(13);
      check_val("bounce_setting_on", int'(Setting), 1);
      MinButton = 1'b0;
      wait_edge(19);
      check_val("bounce_setting_off", int'(Setting), 0);
      wait_edge(70);
      check_val("bounce_left", sb_q.size(), 0);

      // Minute held 40 cycles: first pulse, delay, then repeat cadence; prescaler restarts.
      do_reset(1'b0);
      wait_edge(10);
      MinButton = 1'b1;
      push_exp(17, K_MIN);
      push_exp(33, K_MIN);
      push_exp(37, K_MIN);
      push_exp(41, K_MIN);
      push_exp(45, K_MIN);
      push_exp(49, K_MIN);
      push_exp(109, K_TICK);
      wait_edge(30);
      check_val("hold_setting", int'(Setting), 1);
      wait_edge(50);
      MinButton = 1'b0;
      wait_edge(120);
      check_val("hold_setting_off", int'(Setting), 0);
      check_val("hold_left", sb_q.size(), 0);

      // Both buttons on the same edge: minute first, hour the next cycle.
      do_reset(1'b0);
      wait_edge(10);
      MinButton = 1'b1;
      HourButton = 1'b1;
      push_exp(17, K_MIN);
      push_exp(18, K_HOUR);
      push_exp(77, K_TICK);
      wait_edge(20);
      MinButton = 1'b0;
      HourButton = 1'b0;
      wait_edge(85);
      check_val("both_left", sb_q.size(), 0);

      // Hour pulse coinciding with a prescaler wrap: tick deferred by one cycle.
      do_reset(1'b0);
      wait_edge(53);
      HourButton = 1'b1;
      push_exp(60, K_HOUR);
      push_exp(61, K_TICK);
      push_exp(120, K_TICK);
      wait_edge(58);
      HourButton = 1'b0;
      wait_edge(125);
      check_val("coinc_left", sb_q.size(), 0);

      // Reset pulse during repeat: outputs drop at once, held button restarts as a new press.
      do_reset(1'b0);
      wait_edge(10);
      MinButton = 1'b1;
      push_exp(17, K_MIN);
      push_exp(33, K_MIN);
      push_exp(37, K_MIN);
      wait_edge(40);
      @(posedge Clock);
      #2;
      nReset = 1'b0;
      #1;
      check_val("midrst_outs", int'({Tick, SyncMinOut, SyncHourOut, Setting}), 0);
      check_val("midrst_left", sb_q.size(), 0);
      push_exp(7, K_MIN);
      push_exp(67, K_TICK);
      @(posedge Clock);
      #2;
      nReset = 1'b1;
      wait_edge(10);
      MinButton = 1'b0;
      wait_edge(75);
      check_val("rerun_left", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
